// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between a CPU port (A) and a
// DMA/debug port (B), with a bounded B burst lock and address checking.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration and request capture happen here
// ACCESS | memory strobed from the captured request for one cycle
// DONE   | winner's Ack/Err pulse; memory idle
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int INDEX_BITS = 8,
  parameter int BURST_MAX  = 8
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  AReq,
  input  logic                  AWrite,
  input  logic [ADDR_WIDTH-1:0] AAddress,
  input  logic [DATA_WIDTH-1:0] AWriteData,
  output logic                  AAck,
  output logic                  AErr,
  output logic [DATA_WIDTH-1:0] AReadData,
  input  logic                  BReq,
  input  logic                  BWrite,
  input  logic [ADDR_WIDTH-1:0] BAddress,
  input  logic [DATA_WIDTH-1:0] BWriteData,
  output logic                  BAck,
  output logic                  BErr,
  output logic [DATA_WIDTH-1:0] BReadData,
  input  logic                  BLock,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemoryRead,
  output logic                  MemoryWrite,
  input  logic [DATA_WIDTH-1:0] MemReadData,
  output logic                  Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(BURST_MAX);

  state_t                state, state_next;
  logic                  last_grant_b;
  logic [CNT_W-1:0]      burst_cnt;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  write_reg;
  logic                  port_b_reg;
  logic                  err_reg;
  logic                  any_req;
  logic                  grant_b;
  logic                  take_req;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_err;

  assign any_req  = AReq | BReq;
  assign take_req = (state == IDLE) && any_req;

  // B keeps the memory only while it asks for a lock, won last, and the burst is not exhausted
  always_comb begin
    grant_b = 1'b0;
    if (BReq && !AReq) begin
      grant_b = 1'b1;
    end else if (AReq && BReq) begin
      if (BLock && last_grant_b && (burst_cnt < BURST_LIMIT)) grant_b = 1'b1;
      else                                                    grant_b = !last_grant_b;
    end
  end

  assign sel_addr = grant_b ? BAddress : AAddress;
  assign sel_err  = (|sel_addr[2:0]) | (|sel_addr[ADDR_WIDTH-1:INDEX_BITS+3]);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    MemAddress   = '0;
    MemWriteData = '0;
    MemoryRead   = 1'b0;
    MemoryWrite  = 1'b0;
    AAck         = 1'b0;
    AErr         = 1'b0;
    BAck         = 1'b0;
    BErr         = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        MemAddress   = addr_reg;
        MemWriteData = wdata_reg;
        MemoryRead   = !write_reg && !err_reg;
        MemoryWrite  = write_reg && !err_reg;
        state_next   = DONE;
      end
      DONE: begin
        AAck       = !port_b_reg;
        AErr       = !port_b_reg && err_reg;
        BAck       = port_b_reg;
        BErr       = port_b_reg && err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      last_grant_b <= 1'b1;
      burst_cnt    <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      write_reg    <= 1'b0;
      port_b_reg   <= 1'b0;
      err_reg      <= 1'b0;
      AReadData    <= '0;
      BReadData    <= '0;
    end else begin
      if (take_req) begin
        addr_reg     <= sel_addr;
        wdata_reg    <= grant_b ? BWriteData : AWriteData;
        write_reg    <= grant_b ? BWrite : AWrite;
        port_b_reg   <= grant_b;
        err_reg      <= sel_err;
        last_grant_b <= grant_b;
      end

      if (!AReq) begin
        burst_cnt <= '0;
      end else if (take_req) begin
        if (!grant_b)                      burst_cnt <= '0;
        else if (burst_cnt != BURST_LIMIT) burst_cnt <= burst_cnt + 1'b1;
      end

      // stores leave the read-data registers untouched
      if ((state == ACCESS) && !write_reg) begin
        if (port_b_reg) BReadData <= err_reg ? '0 : MemReadData;
        else            AReadData <= err_reg ? '0 : MemReadData;
      end
    end
  end

endmodule
